// File: rtl/tpu_pkg.sv
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared types and constants for the matmul_engine compute stage.
//            Holds the FSM state encoding, the accumulator width, the number of
//            output beats per result set and the output saturation bounds.
// Config   : SATURATE_EN - when defined, each C element is clamped to one
//            signed byte and NUM_BEATS becomes 4 (otherwise 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_pkg;

  localparam int DATA_W     = 8;
  localparam int ACC_W      = 2 * DATA_W;
  localparam int BEAT_IDX_W = 3;

`ifdef SATURATE_EN
  localparam int NUM_BEATS = 4;
`else
  localparam int NUM_BEATS = 8;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC0   = 2'd1,
    MAC1   = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 16'sd127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -16'sd128;

  // Clamp a C element to one signed byte. 0x8000 can only come from the
  // wrap of +32768 ((-128)*(-128) twice); no legal sum reaches -32768, so it
  // is treated as positive overflow.
  function automatic logic [DATA_W-1:0] sat_byte(input logic signed [ACC_W-1:0] v);
    logic [DATA_W-1:0] res;
    if (v == {1'b1, {(ACC_W-1){1'b0}}})
      res = SAT_MAX[DATA_W-1:0];
    else if (v > SAT_MAX)
      res = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN)
      res = SAT_MIN[DATA_W-1:0];
    else
      res = v[DATA_W-1:0];
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_engine_mac_cell.sv
// ============================================================================
// Module   : mac_cell
// Purpose  : One signed multiply-accumulate cell. Multiplies two signed
//            DATA_W operands, sign-extends the product to ACC_W and adds it
//            to a local accumulator (modulo 2^ACC_W).
// Ports    : clk, rst   - clock, synchronous active-high reset
//            clear      - zero the accumulator (wins over en)
//            en         - accumulate a*b this edge
//            a, b       - signed operands
//            acc        - accumulator value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_cell #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic [DATA_W-1:0]       a,
  input  logic [DATA_W-1:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = ACC_W'(prod);  // signed cast sign-extends

  always_ff @(posedge clk) begin
    if (rst || clear)
      acc <= '0;
    else if (en)
      acc <= acc + prod_ext;
  end

endmodule

`default_nettype wire

// File: rtl/matmul_engine.sv
// ============================================================================
// Module   : matmul_engine
// Purpose  : 2x2 signed matrix multiply C = A x B. On start the eight operand
//            bytes are snapshotted, four mac_cells accumulate over two cycles
//            (MAC0, MAC1), then results stream out byte-serially over a
//            valid/ready handshake. done pulses for one cycle after the final
//            beat is accepted.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            start            - begin operation (sampled only in IDLE)
//            weights[0:3]     - A[r][c] = weights[2r+c], signed
//            inputs[0:3]      - B[r][c] = inputs[2r+c], signed
//            busy             - high in every state except IDLE
//            out_valid/ready  - output handshake
//            out_data         - result beat
//            done             - one-cycle completion pulse
// Config   : SATURATE_EN - emit each C element clamped to one byte (4 beats:
//            C00, C01, C10, C11); otherwise 8 beats, row-major, low byte first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] weights [0:3],
  input  logic [DATA_W-1:0] inputs  [0:3],
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  import tpu_pkg::*;

  state_t                  state;
  logic [DATA_W-1:0]       w_q  [0:3];
  logic [DATA_W-1:0]       in_q [0:3];
  logic [BEAT_IDX_W-1:0]   beat_idx;
  logic signed [ACC_W-1:0] acc  [0:3];

  logic mac_clear;
  logic mac_en;
  logic mac_k;    // which inner-product term: 0 in MAC0, 1 in MAC1

  assign mac_clear = (state == IDLE) && start;
  assign mac_en    = (state == MAC0) || (state == MAC1);
  assign mac_k     = (state == MAC1);

  // Cell (r,c) accumulates A[r][k] * B[k][c] for k = mac_k.
  genvar r, c;
  generate
    for (r = 0; r < 2; r++) begin : g_row
      for (c = 0; c < 2; c++) begin : g_col
        mac_cell #(
          .DATA_W (DATA_W),
          .ACC_W  (ACC_W)
        ) u_mac (
          .clk   (clk),
          .rst   (rst),
          .clear (mac_clear),
          .en    (mac_en),
          .a     (mac_k ? w_q[2*r+1] : w_q[2*r]),
          .b     (mac_k ? in_q[2+c]  : in_q[c]),
          .acc   (acc[2*r+c])
        );
      end
    end
  endgenerate

  // Beat selection. Output is forced to zero when no beat is presented.
  logic [DATA_W-1:0] beat;
`ifndef SATURATE_EN
  logic [ACC_W-1:0]  beat_elem;
`endif

  always_comb begin
    beat = '0;
`ifdef SATURATE_EN
    beat = sat_byte(acc[beat_idx[1:0]]);
`else
    beat_elem = acc[beat_idx[2:1]];
    beat      = beat_idx[0] ? beat_elem[ACC_W-1:DATA_W] : beat_elem[DATA_W-1:0];
`endif
    out_data = out_valid ? beat : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      beat_idx  <= '0;
      for (int i = 0; i < 4; i++) begin
        w_q[i]  <= '0;
        in_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 4; i++) begin
              w_q[i]  <= weights[i];
              in_q[i] <= inputs[i];
            end
            busy  <= 1'b1;
            state <= MAC0;
          end
        end
        MAC0: begin
          state <= MAC1;
        end
        MAC1: begin
          beat_idx  <= '0;
          out_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            if (beat_idx == BEAT_IDX_W'(NUM_BEATS - 1)) begin
              beat_idx  <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_engine.sv
// ============================================================================
// Module   : tb_matmul_engine
// Purpose  : Self-checking bench for matmul_engine. Directed cases plus
//            randomized operands and out_ready patterns, compared against an
//            integer-arithmetic matrix-product model.
// Config   : honours SATURATE_EN in the expected beat model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_engine;

`ifdef SATURATE_EN
  localparam int NB = 4;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] weights [0:3];
  logic [7:0] inputs  [0:3];
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cur_w [0:3];
  logic [7:0] cur_i [0:3];
  int         exp_beats [0:7];

  always #5 clk = ~clk;

  matmul_engine #(.DATA_W(8), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .weights   (weights),
    .inputs    (inputs),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input logic [7:0] v);
    int t;
    t = {{24{v[7]}}, v};
    return t;
  endfunction

  // C[r][c] = sum_k A[r][k]*B[k][c] in plain integers, then formatted.
  task automatic compute_expected();
    int s, r, c;
    for (int e = 0; e < 4; e++) begin
      r = e / 2;
      c = e % 2;
      s = sx(cur_w[2*r]) * sx(cur_i[c]) + sx(cur_w[2*r+1]) * sx(cur_i[2+c]);
`ifdef SATURATE_EN
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      exp_beats[e] = s & 255;
`else
      exp_beats[2*e]   = s & 255;
      exp_beats[2*e+1] = (s & 65535) >> 8;
`endif
    end
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 3))
      0:       return 8'h80;
      1:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic set_ops(input logic [31:0] w, input logic [31:0] i);
    for (int k = 0; k < 4; k++) begin
      cur_w[k] = w[31-8*k -: 8];
      cur_i[k] = i[31-8*k -: 8];
    end
  endtask

  // mode 0: out_ready always high; 1: low for first 3 presented cycles;
  // 2: random. mess: scramble operand memory and hold start high after launch.
  task automatic do_run(input int mode, input bit mess);
    int  k, cyc, hold;
    bit  rdy;
    compute_expected();
    for (int i = 0; i < 4; i++) begin
      weights[i] = cur_w[i];
      inputs[i]  = cur_i[i];
    end
    start     = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = mess;
    check_value("busy_after_start", busy, 1);
    check_value("valid_t1", out_valid, 0);
    check_value("done_t1", done, 0);
    if (mess) begin
      for (int i = 0; i < 4; i++) begin
        weights[i] = 8'($urandom);
        inputs[i]  = 8'($urandom);
      end
    end
    @(negedge clk);
    check_value("valid_t2", out_valid, 0);
    check_value("busy_t2", busy, 1);
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0; hold = 0;
    while (k < NB && cyc < 200) begin
      check_value("valid", out_valid, 1);
      check_value("busy", busy, 1);
      check_value("done_mid", done, 0);
      check_value($sformatf("beat%0d", k), out_data, exp_beats[k]);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (hold >= 3);
      else                rdy = ($urandom_range(0, 3) != 0);
      hold++;
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    if (cyc >= 200) check_value("stream_timeout", 0, 1);
    if (mode == 0) check_value("beat_cycles", cyc, NB);
    if (mode == 1) check_value("beat_cycles_bp", cyc, NB + 3);
    out_ready = 1'b0;
    check_value("done_pulse", done, 1);
    check_value("busy_end", busy, 0);
    check_value("valid_end", out_valid, 0);
    @(negedge clk);
    check_value("done_clear", done, 0);
    check_value("busy_idle", busy, 0);
    check_value("valid_idle", out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      weights[i] = '0;
      inputs[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check_value("rst_busy", busy, 0);
    check_value("rst_valid", out_valid, 0);
    check_value("rst_data", out_data, 0);
    check_value("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    set_ops(32'h01020304, 32'h05060708);  do_run(0, 1'b0);
    set_ops(32'hFF0000FF, 32'h02030405);  do_run(0, 1'b0);
    set_ops(32'h80808080, 32'h80808080);  do_run(2, 1'b0);
    set_ops(32'h01020304, 32'h05060708);  do_run(1, 1'b0);
    set_ops(32'h01020304, 32'h05060708);  do_run(2, 1'b1);

    // Abort mid-stream with rst after three beats have transferred.
    set_ops(32'h01020304, 32'h05060708);
    compute_expected();
    for (int i = 0; i < 4; i++) begin
      weights[i] = cur_w[i];
      inputs[i]  = cur_i[i];
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_value("abort_beat3", out_data, exp_beats[3]);
    rst = 1'b1;
    @(negedge clk);
    check_value("abort_valid", out_valid, 0);
    check_value("abort_busy", busy, 0);
    check_value("abort_done", done, 0);
    check_value("abort_data", out_data, 0);
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_value("abort_done2", done, 0);
    do_run(0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        cur_w[i] = pick_byte();
        cur_i[i] = pick_byte();
      end
      do_run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/matmul_engine.md
# matmul_engine

Compute stage directly downstream of the 8-byte operand memory. On a start pulse it snapshots the four weight bytes (matrix A) and four input bytes (matrix B) and computes the 2x2 signed product C = A x B with four parallel MAC cells over two cycles. It then streams the results out byte-serially over a valid/ready handshake toward the output pins.

## Interface
- DATA_W, 8: operand and output byte width.
- ACC_W, 16: result width per C element (2*DATA_W).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin operation; sampled only in IDLE.
- weights[0:3]  in  DATA_W each  A[r][c] = weights[2r+c], signed two's complement.
- inputs[0:3]  in  DATA_W each  B[r][c] = inputs[2r+c], signed.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  consumer accepts the beat this cycle.
- out_data  out  DATA_W  result beat.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, MAC0, MAC1, STREAM.
- IDLE, start=1 at an edge: latch all 8 operand bytes into local registers, clear the four accumulators, go to MAC0. Memory may change afterward without affecting results.
- MAC0 edge: acc[r][c] += A[r][0]*B[0][c], then go to MAC1.
- MAC1 edge: acc[r][c] += A[r][1]*B[1][c], beat index = 0, then go to STREAM.
- Arithmetic: 8x8 signed product, sign-extended to ACC_W. Sum is modulo 2^ACC_W. The only overflow case is two (-128)*(-128) terms: 32768 wraps to 0x8000.
- STREAM: out_valid=1, out_data = beat[index]. At each edge with out_ready=1, index increments. When the last beat is accepted, go to IDLE and assert done for the next cycle.
- Beat order, default: C00[7:0], C00[15:8], C01 lo, C01 hi, C10 lo, C10 hi, C11 lo, C11 hi. That is 8 beats, row-major, low byte first.
- start is ignored when the state is not IDLE.
- out_ready is ignored outside STREAM.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, done=0, state=IDLE, accumulators and index = 0.
- Latency: start sampled at edge T. busy=1 from T. out_valid first high after edge T+2, so the first beat is presented 3 cycles after start is sampled.
- A beat transfers at an edge where out_valid and out_ready are both high. With out_ready held high, N beats take N cycles.
- With out_ready=0, out_data and out_valid hold stable.
- After the final transfer at edge E: out_valid=0, busy=0, done=1 during cycle E..E+1. done is high in the same cycle IDLE is re-entered.
- A new start may be sampled at edge E+1; done is still high then, and done does not block the start.
- rst at any state wins over all other inputs. The block goes to IDLE with all outputs at reset values, the stream is aborted, and done is not pulsed.

## Configuration
- SATURATE_EN defined: each C element is clamped to [-128, 127] and emitted as a single byte. Beat order is C00, C01, C10, C11, so 4 beats.
- SATURATE_EN undefined: full ACC_W results are emitted as 8 beats, as in Operation.
- Accumulation is identical in both builds. Saturation applies only at output selection.

## Structure
- Package tpu_pkg holds: state enum (IDLE, MAC0, MAC1, STREAM); ACC_W; NUM_BEATS (8, or 4 under SATURATE_EN); the saturation bounds.
- Sub-module mac_cell, instantiated 4x. It takes a, b, clear and en, and holds one ACC_W signed accumulator. The top level owns the FSM, the operand snapshot and the beat mux.

## Test plan
- A=[1,2;3,4], B=[5,6;7,8], start, out_ready=1 → beats 0x13,00,0x16,00,0x2B,00,0x32,00. done pulses one cycle after the last beat; busy is low on the same cycle.
- A=[0xFF,0;0,0xFF] (i.e. -I), B=[2,3;4,5] → beats FE,FF,FD,FF,FC,FF,FB,FF.
- All operands 0x80 → each C = 0x8000, beats 00,80 repeated 4x. With SATURATE_EN: 7F,7F,7F,7F.
- Backpressure: out_ready=0 for 3 cycles after the first beat is presented → out_data holds 0x13 and out_valid stays 1. No beat is lost or duplicated.
- Snapshot and start-while-busy: overwrite memory and pulse start during MAC1/STREAM → results match the original operands, and no second run occurs.
- rst asserted mid-STREAM (after beat 3) → next cycle out_valid=0, busy=0, done=0. A fresh start yields the full 8-beat sequence.
